// File: rtl/pattern_detector.sv
// ============================================================================
// Module   : pattern_detector
// Brief    : Serial N-bit pattern detector (KMP automaton), saturating count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_detector #(
  parameter int          N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit          OVERLAP = 1'b1,
  parameter bit          MOORE   = 1'b0,
  parameter int          CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          x,
  input  logic          clr_count,
  output logic          y,
  output logic [CW-1:0] count
);

  localparam int KW = $clog2(N);

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b),
  // capped at N-1 so a full match folds into the overlap restart state.
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   j;
    bit   ok;
    logic sbit;
    best = 0;
    for (int l = 1; l <= 8; l++) begin
      if (l <= k + 1 && l <= N - 1) begin
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (i < l) begin
            j    = k + 1 - l + i;
            sbit = (j == k) ? b : PATTERN[N-1-j];
            if (sbit != PATTERN[N-1-i]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  function automatic logic [N*KW-1:0] build_tab(input logic b);
    logic [N*KW-1:0] tab;
    tab = '0;
    for (int k = 0; k < N; k++) begin
      tab[k*KW +: KW] = KW'(kmp_next(k, b));
    end
    return tab;
  endfunction

  localparam logic [N*KW-1:0] c_tab0      = build_tab(1'b0);
  localparam logic [N*KW-1:0] c_tab1      = build_tab(1'b1);
  localparam logic [KW-1:0]   c_last      = KW'(N - 1);
  localparam logic [CW-1:0]   c_count_max = '1;

  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_next;
  logic          w_match;
  logic [CW-1:0] r_count;

  always_comb begin
    w_match  = en & (r_k == c_last) & (x == PATTERN[0]);
    w_k_next = r_k;
    if (en) begin
      w_k_next = '0;
      for (int i = 0; i < N; i++) begin
        if (r_k == KW'(i)) begin
          w_k_next = x ? c_tab1[i*KW +: KW] : c_tab0[i*KW +: KW];
        end
      end
      if (w_match && !OVERLAP) w_k_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_count <= '0;
    end else begin
      r_k <= w_k_next;
      if (clr_count) begin
        r_count <= w_match ? CW'(1) : '0;
      end else if (w_match && r_count != c_count_max) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign count = r_count;

  generate
    if (MOORE) begin : g_moore
      logic r_y;
      always_ff @(posedge clk) begin
        if (reset) r_y <= 1'b0;
        else       r_y <= w_match;
      end
      assign y = r_y;
    end else begin : g_mealy
      assign y = w_match & ~reset;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pattern_detector.sv
// ============================================================================
// Module   : tb_pattern_detector
// Brief    : Five detector configurations on shared stimulus, vector table
//            plus history-based reference model feeding a scoreboard queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_detector;

  logic       clk;
  logic       reset;
  logic       en;
  logic       x;
  logic       clr_count;
  logic [4:0] y_v;
  logic [7:0] c_v [4];
  logic [1:0] c4;

  int checks   = 0;
  int failures = 0;

  // u0 defaults, u1 no-overlap, u2 1101 Mealy, u3 1101 Moore, u4 CW=2
  pattern_detector u0 (.clk(clk), .reset(reset), .en(en), .x(x),
                       .clr_count(clr_count), .y(y_v[0]), .count(c_v[0]));
  pattern_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(reset), .en(en),
                       .x(x), .clr_count(clr_count), .y(y_v[1]), .count(c_v[1]));
  pattern_detector #(.N(4), .PATTERN(4'b1101)) u2 (.clk(clk), .reset(reset),
                       .en(en), .x(x), .clr_count(clr_count), .y(y_v[2]),
                       .count(c_v[2]));
  pattern_detector #(.N(4), .PATTERN(4'b1101), .MOORE(1'b1)) u3 (.clk(clk),
                       .reset(reset), .en(en), .x(x), .clr_count(clr_count),
                       .y(y_v[3]), .count(c_v[3]));
  pattern_detector #(.CW(2)) u4 (.clk(clk), .reset(reset), .en(en), .x(x),
                       .clr_count(clr_count), .y(y_v[4]), .count(c4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       x;
    logic       clr;
    logic       y;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic [4:0] ym;
    logic [7:0] c [5];
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  int         mn  [5] = '{3, 3, 4, 4, 3};
  logic [7:0] mp  [5] = '{8'h05, 8'h05, 8'h0D, 8'h0D, 8'h05};
  bit         mo  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int         mcw [5] = '{8, 8, 8, 8, 2};
  logic [7:0] hist[5] = '{default: 8'd0};
  int         hlen[5] = '{default: 0};
  int         mcnt[5] = '{default: 0};

  logic [4:0] last_ym;
  logic [7:0] last_c [5];
  logic       last_y3;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic xi,
                              input logic c, input logic yy, input int cn);
    vec_t v;
    v.rst = r; v.en = e; v.x = xi; v.clr = c; v.y = yy; v.cnt = 8'(cn);
    return v;
  endfunction

  // Reference: match when the last N bits since the search (re)started equal
  // the pattern; no-overlap forgets the history after a match.
  task automatic step(input logic r, input logic e, input logic xi,
                      input logic c);
    exp_t       ex;
    exp_t       got;
    logic [7:0] w;
    logic [7:0] mask;
    logic       m;
    int         mx;
    reset = r; en = e; x = xi; clr_count = c;
    for (int i = 0; i < 5; i++) begin
      mask = (8'd1 << mn[i]) - 8'd1;
      w    = ((hist[i] << 1) | {7'd0, xi}) & mask;
      m    = !r && e && (hlen[i] + 1 >= mn[i]) && (w == mp[i]);
      ex.ym[i] = m;
      mx = (1 << mcw[i]) - 1;
      if (r) begin
        hist[i] = 8'd0; hlen[i] = 0; mcnt[i] = 0;
      end else begin
        if (c)                      mcnt[i] = m ? 1 : 0;
        else if (m && mcnt[i] < mx) mcnt[i]++;
        if (e) begin
          if (m && !mo[i]) begin
            hist[i] = 8'd0; hlen[i] = 0;
          end else begin
            hist[i] = w; hlen[i] = (hlen[i] < 8) ? hlen[i] + 1 : 8;
          end
        end
      end
      ex.c[i] = 8'(mcnt[i]);
    end
    sb.push_back(ex);
    @(negedge clk);
    got.ym = y_v;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) got.c[i] = c_v[i];
    got.c[4] = {6'd0, c4};
    last_y3  = y_v[3];
    ex = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i != 3) chk($sformatf("u%0d_y", i), 32'(got.ym[i]), 32'(ex.ym[i]));
      chk($sformatf("u%0d_count", i), 32'(got.c[i]), 32'(ex.c[i]));
      last_c[i] = got.c[i];
    end
    chk("u3_moore_y", 32'(last_y3), 32'(ex.ym[3]));
    last_ym = got.ym;
  endtask

  task automatic run_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; x = 1'b0; clr_count = 1'b0;
    @(posedge clk);
    #1;

    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));

    foreach (vecs[v]) begin
      step(vecs[v].rst, vecs[v].en, vecs[v].x, vecs[v].clr);
      chk($sformatf("vec%0d_y", v), 32'(last_ym[0]), 32'(vecs[v].y));
      chk($sformatf("vec%0d_count", v), 32'(last_c[0]), 32'(vecs[v].cnt));
    end

    // 1101 after 1,1,1,0,1: Mealy fires on sample 5, Moore just after it
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_bits(16'b1110, 4);
    chk("seq1101_s4_mealy", 32'(last_ym[2]), 32'd0);
    chk("seq1101_s4_moore", 32'(last_y3), 32'd0);
    run_bits(16'b1, 1);
    chk("seq1101_s5_mealy", 32'(last_ym[2]), 32'd1);
    chk("seq1101_s5_moore", 32'(last_y3), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("seq1101_s6_moore", 32'(last_y3), 32'd0);

    // CW=2 saturation over five overlapping matches, then clear-with-match
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_bits(16'b1010101, 7);
    chk("sat_after3", 32'(last_c[4]), 32'd3);
    run_bits(16'b01, 2);
    chk("sat_after4", 32'(last_c[4]), 32'd3);
    run_bits(16'b01, 2);
    chk("sat_after5", 32'(last_c[4]), 32'd3);
    chk("nosat_after5", 32'(last_c[0]), 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("sat_clr_match", 32'(last_c[4]), 32'd1);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
